spypath_delay_meter: RTL and testbench
======================================

// Module: spypath_delay_meter
// PURPOSE
//   Launch/capture controller directly upstream and downstream of a spypath chain.
//   Drives the chain's pathInput, resynchronises its pathResult, and measures propagation
//   delay in clk cycles over a programmable number of trials. Each trial toggles the launch
//   level, so rising and falling edges alternate. Publishes last, sum, min and max delay.
// PARAMETERS
//   CNT_W     16    width of per-trial delay counter and last_delay
//   TRIALS_W  8     width of num_trials
//   TIMEOUT   1000  max count per settle/measure phase; must be < 2**CNT_W
//   PATH_INV  0     1 if the chain has an odd number of inverting stages
// PORTS
//   clk          in   1                   system clock
//   rst_n        in   1                   asynchronous, active-low reset
//   start        in   1                   1-cycle pulse; begins a run when idle
//   num_trials   in   TRIALS_W            trials per run, sampled on accepted start
//   path_launch  out  1                   registered drive to chain pathInput
//   path_result  in   1                   chain pathResult; asynchronous to clk
//   busy         out  1                   high from accepted start until done
//   done         out  1                   1-cycle pulse at end of run
//   timeout_err  out  1                   sticky per run; run aborted on timeout
//   last_delay   out  CNT_W               delay of most recent trial
//   delay_sum    out  CNT_W+TRIALS_W      sum of delays in this run
//   min_delay    out  CNT_W               smallest trial delay (see CONFIGURATION)
//   max_delay    out  CNT_W               largest trial delay (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, path_launch=0, synchroniser flops=0, FSM=IDLE.
//   Asserting rst_n mid-run aborts immediately. No done pulse.
// - path_result passes through a 2-flop synchroniser (sync). expected = path_launch ^ PATH_INV.
// - FSM states: IDLE, SETTLE, MEASURE, FIN.
// - IDLE, on start:
//   - latch num_trials; clear delay_sum, last_delay, timeout_err; min_delay=all-ones; max_delay=0.
//   - busy=1. Go to FIN if num_trials==0, else SETTLE.
//   - start while busy is ignored.
// - SETTLE: wait for sync==expected, using cnt as a timeout counter.
//   - On match: toggle path_launch, load cnt=1, go MEASURE.
//   - cnt reaching TIMEOUT without a match: timeout_err=1, go FIN.
// - MEASURE, each edge:
//   - if sync==expected: capture last_delay=cnt; delay_sum+=cnt; update min/max; trial_idx++.
//     Go FIN if trial_idx reaches num_trials, else SETTLE.
//   - else if cnt==TIMEOUT: last_delay=TIMEOUT, timeout_err=1, go FIN. Stats are not updated.
//   - else cnt++.
// - Ideal wire path (zero delay) yields delay 3 (1 launch + 2 sync cycles).
//   A path of D full clk cycles yields 3+D.
// - FIN: done=1 for one cycle, busy=0, return to IDLE. path_launch holds its level between runs.
// - Arithmetic: unsigned. delay_sum cannot overflow (TIMEOUT < 2**CNT_W, trials < 2**TRIALS_W).
// - Outputs hold their values until the next accepted start.
// CONFIGURATION
// - SPY_MINMAX_EN defined: min_delay/max_delay are tracked as above.
// - SPY_MINMAX_EN undefined: no min/max registers are built; min_delay and max_delay are tied to 0.
// TESTING
// - Wire model, PATH_INV=0, num_trials=4 -> last_delay=3 each trial, delay_sum=12, min=max=3,
//   one done pulse, timeout_err=0.
// - Model with rise delay 5 cycles, fall delay 2, num_trials=4 -> delays 8,5,8,5; sum=26; min=5, max=8.
// - path_result stuck 0, TIMEOUT=16, num_trials=3 -> SETTLE passes, first MEASURE times out:
//   timeout_err=1, last_delay=16, delay_sum=0, done.
// - PATH_INV=1 with inverter model, num_trials=2 -> delays 3,3; sum=6; no timeout.
// - num_trials=0 -> done pulse 2 cycles after start, sum=0, path_launch unchanged.
//   A second start while busy -> ignored.
// - rst_n low mid-MEASURE -> all outputs and path_launch 0 asynchronously.
//   A fresh run after release behaves as the wire-model test.

Source files
------------

// File: rtl/spypath_delay_meter.sv
// Launch/capture controller around a spypath chain: toggles the launch level per trial and
// measures resynchronised return delay in clk cycles. Optional min/max tracking: SPY_MINMAX_EN.
module spypath_delay_meter #(
    parameter int CNT_W    = 16,
    parameter int TRIALS_W = 8,
    parameter int TIMEOUT  = 1000,
    parameter int PATH_INV = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [TRIALS_W-1:0]       num_trials,
    output logic                      path_launch,
    input  logic                      path_result,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          last_delay,
    output logic [CNT_W+TRIALS_W-1:0] delay_sum,
    output logic [CNT_W-1:0]          min_delay,
    output logic [CNT_W-1:0]          max_delay,
    output logic [1:0]                fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] FIN     = 2'd3;

    localparam int               SUM_W       = CNT_W + TRIALS_W;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic             INV         = (PATH_INV != 0);

    logic [1:0]          state;
    logic                syncMeta;
    logic                syncOut;
    logic [CNT_W-1:0]    cnt;
    logic [TRIALS_W-1:0] trialIdx;
    logic [TRIALS_W-1:0] trialTarget;
    logic [TRIALS_W-1:0] nextIdx;
    logic                match;
    logic                startAcc;
    logic                capture;
    logic                cntAtLimit;

    // Handshake: start is a single-cycle request, accepted only in IDLE; busy covers the
    // accepted run and drops in the same cycle that done pulses.
    assign fsm_state  = state;
    assign match      = (syncOut == (path_launch ^ INV));
    assign startAcc   = (state == IDLE) && start;
    assign capture    = (state == MEASURE) && match;
    assign cntAtLimit = (cnt == TIMEOUT_CNT);
    assign nextIdx    = trialIdx + 1'b1;

    // path_result is asynchronous to clk; two flops before any decision is made on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= 1'b0;
            syncOut  <= 1'b0;
        end else begin
            syncMeta <= path_result;
            syncOut  <= syncMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            path_launch <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            last_delay  <= '0;
            delay_sum   <= '0;
            cnt         <= '0;
            trialIdx    <= '0;
            trialTarget <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startAcc) begin
                        trialTarget <= num_trials;
                        trialIdx    <= '0;
                        cnt         <= '0;
                        delay_sum   <= '0;
                        last_delay  <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (num_trials == '0) ? FIN : SETTLE;
                    end
                end
                SETTLE: begin
                    if (match) begin
                        // The counter starts at 1 so the launch cycle itself is counted.
                        path_launch <= ~path_launch;
                        cnt         <= CNT_W'(1);
                        state       <= MEASURE;
                    end else if (cntAtLimit) begin
                        timeout_err <= 1'b1;
                        state       <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (match) begin
                        last_delay <= cnt;
                        delay_sum  <= delay_sum + SUM_W'(cnt);
                        trialIdx   <= nextIdx;
                        cnt        <= '0;
                        state      <= (nextIdx == trialTarget) ? FIN : SETTLE;
                    end else if (cntAtLimit) begin
                        last_delay  <= TIMEOUT_CNT;
                        timeout_err <= 1'b1;
                        state       <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPY_MINMAX_EN
    // Min starts at all-ones so the first completed trial always replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_delay <= '0;
            max_delay <= '0;
        end else if (startAcc) begin
            min_delay <= '1;
            max_delay <= '0;
        end else if (capture) begin
            if (cnt < min_delay) min_delay <= cnt;
            if (cnt > max_delay) max_delay <= cnt;
        end
    end
`else
    assign min_delay = '0;
    assign max_delay = '0;
`endif

endmodule

// File: tb/tb_spypath_delay_meter.sv
// Bench for spypath_delay_meter: a delayed-chain model drives path_result, and a run-level
// model predicts the statistics, run length and final launch level of every run.
module tb_spypath_delay_meter;

    localparam int CNT_W    = 16;
    localparam int TRIALS_W = 8;
    localparam int TMO      = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [TRIALS_W-1:0]       num_trials = '0;
    logic                      path_launch;
    logic                      path_result;
    logic                      busy, done, timeout_err;
    logic [CNT_W-1:0]          last_delay, min_delay, max_delay;
    logic [CNT_W+TRIALS_W-1:0] delay_sum;
    logic [1:0]                fsm_state;

    logic                      startInv = 1'b0;
    logic [TRIALS_W-1:0]       numInv = '0;
    logic                      launchInv, resultInv;
    logic                      busyInv, doneInv, toInv;
    logic [CNT_W-1:0]          lastInv, minInv, maxInv;
    logic [CNT_W+TRIALS_W-1:0] sumInv;
    logic [1:0]                stateInv;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    spypath_delay_meter #(.CNT_W(CNT_W), .TRIALS_W(TRIALS_W), .TIMEOUT(TMO), .PATH_INV(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_trials(num_trials),
        .path_launch(path_launch), .path_result(path_result), .busy(busy), .done(done),
        .timeout_err(timeout_err), .last_delay(last_delay), .delay_sum(delay_sum),
        .min_delay(min_delay), .max_delay(max_delay), .fsm_state(fsm_state)
    );

    spypath_delay_meter #(.CNT_W(CNT_W), .TRIALS_W(TRIALS_W), .TIMEOUT(TMO), .PATH_INV(1)) dutInv (
        .clk(clk), .rst_n(rst_n), .start(startInv), .num_trials(numInv),
        .path_launch(launchInv), .path_result(resultInv), .busy(busyInv), .done(doneInv),
        .timeout_err(toInv), .last_delay(lastInv), .delay_sum(sumInv),
        .min_delay(minInv), .max_delay(maxInv), .fsm_state(stateInv)
    );

    // Single inverting stage with no delay.
    assign resultInv = ~launchInv;

    // Chain model: a launch transition reaches path_result after riseDly/fallDly full cycles.
    int   riseDly = 0;
    int   fallDly = 0;
    bit   stuck = 1'b0;
    logic lastSeen = 1'b0;
    logic prLevel = 1'b0;
    int   cd = 0;

    always @(negedge clk) begin
        if (path_launch !== lastSeen) begin
            lastSeen = path_launch;
            cd = path_launch ? riseDly : fallDly;
            if (cd == 0) prLevel = path_launch;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) prLevel = lastSeen;
        end
    end
    assign path_result = stuck ? 1'b0 : prLevel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Expected idle-state outputs, held between runs.
    logic [CNT_W-1:0]          expLast = '0, expMin = '0, expMax = '0;
    logic [CNT_W+TRIALS_W-1:0] expSum = '0;
    logic                      expTo = 1'b0, expLaunch = 1'b0;
    bit                        idleCheckEn = 1'b0;

    always @(negedge clk) begin
        if (idleCheckEn) begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_last", last_delay, expLast);
            check("idle_sum", delay_sum, expSum);
            check("idle_timeout", timeout_err, expTo);
            check("idle_min", min_delay, expMin);
            check("idle_max", max_delay, expMax);
            check("idle_launch", path_launch, expLaunch);
        end
    end

    // Run-level model: each trial is one settle cycle plus its delay; a trial whose delay
    // exceeds the limit ends the run with last=limit; a run ends one cycle after its last step.
    task automatic model_run(input int n, input logic l0, input bit stk,
                             output logic [CNT_W-1:0] last, output logic [CNT_W+TRIALS_W-1:0] sum,
                             output logic [CNT_W-1:0] mn, output logic [CNT_W-1:0] mx,
                             output logic to, output logic lEnd, output int lat);
        logic lvl;
        int   d;
        lvl = l0; last = '0; sum = '0; mn = '1; mx = '0; to = 1'b0; lat = 0;
        for (int i = 0; i < n; i++) begin
            if ((stk ? 1'b0 : lvl) != lvl) begin
                to = 1'b1; lat += TMO + 1; break;
            end
            lat += 1;
            lvl = ~lvl;
            d = stk ? TMO + 1 : 3 + (lvl ? riseDly : fallDly);
            if (d > TMO) begin
                last = TMO; to = 1'b1; lat += TMO; break;
            end
            lat += d; last = d; sum += d;
            if (d < mn) mn = d;
            if (d > mx) mx = d;
        end
        lat += 1;
        lEnd = lvl;
    endtask

    task automatic do_run(input int n, input bit extra, input string tag);
        logic [CNT_W-1:0]          mLast, mMin, mMax;
        logic [CNT_W+TRIALS_W-1:0] mSum;
        logic                      mTo, mEnd;
        int                        lat, k, busyBad;
        bit                        got;
        model_run(n, expLaunch, stuck, mLast, mSum, mMin, mMax, mTo, mEnd, lat);
        idleCheckEn = 1'b0;
        @(negedge clk);
        num_trials = TRIALS_W'(n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (extra) begin
            start = 1'b1;
            num_trials = 8'd7;
        end
        k = 0; busyBad = 0; got = 1'b0;
        while (!got && k < 3000) begin
            @(posedge clk);
            #1 start = 1'b0;
            k++;
            @(negedge clk);
            if (done) got = 1'b1;
            else if (busy !== 1'b1) busyBad++;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, k, lat);
        check({tag, "_busy_during"}, busyBad, 0);
        check({tag, "_busy_at_done"}, busy, 0);
        expLast = mLast; expSum = mSum; expTo = mTo; expLaunch = mEnd;
`ifdef SPY_MINMAX_EN
        expMin = mMin; expMax = mMax;
`else
        expMin = '0; expMax = '0;
`endif
        @(posedge clk);
        #1 idleCheckEn = 1'b1;
    endtask

    task automatic pin_minmax(input string tag, input int mn, input int mx);
`ifdef SPY_MINMAX_EN
        check({tag, "_min"}, min_delay, mn);
        check({tag, "_max"}, max_delay, mx);
`else
        check({tag, "_min"}, min_delay, 0);
        check({tag, "_max"}, max_delay, 0);
`endif
    endtask

    initial begin
        int  k;
        bit  got;
        #2;
        check("reset_launch", path_launch, 0);
        check("reset_busy", busy, 0);
        check("reset_sum", delay_sum, 0);
        check("reset_state", fsm_state, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        idleCheckEn = 1'b1;

        // Wire path, with a stray start while busy.
        do_run(4, 1'b1, "wire");
        check("wire_last", last_delay, 3);
        check("wire_sum", delay_sum, 12);
        check("wire_timeout", timeout_err, 0);
        pin_minmax("wire", 3, 3);
        repeat (20) @(posedge clk);

        // Zero trials: done next cycle, launch untouched, stray start ignored.
        do_run(0, 1'b1, "zero");
        check("zero_sum", delay_sum, 0);
        repeat (20) @(posedge clk);

        riseDly = 5; fallDly = 2;
        do_run(4, 1'b0, "risefall");
        check("risefall_last", last_delay, 5);
        check("risefall_sum", delay_sum, 26);
        pin_minmax("risefall", 5, 8);
        repeat (20) @(posedge clk);

        stuck = 1'b1;
        do_run(3, 1'b0, "stuck");
        check("stuck_timeout", timeout_err, 1);
        check("stuck_last", last_delay, 16);
        check("stuck_sum", delay_sum, 0);
        stuck = 1'b0;
        repeat (20) @(posedge clk);

        // Inverting chain on the second instance.
        @(negedge clk);
        numInv = 8'd2; startInv = 1'b1;
        @(posedge clk);
        #1 startInv = 1'b0;
        k = 0; got = 1'b0;
        while (!got && k < 500) begin
            @(negedge clk);
            k++;
            if (doneInv) got = 1'b1;
        end
        check("inv_done_seen", got, 1);
        check("inv_sum", sumInv, 6);
        check("inv_last", lastInv, 3);
        check("inv_timeout", toInv, 0);
        repeat (5) @(posedge clk);

        for (int r = 0; r < 10; r++) begin
            riseDly = $urandom_range(0, 14);
            fallDly = $urandom_range(0, 14);
            repeat (20) @(posedge clk);
            do_run($urandom_range(0, 6), (r % 3) == 0, "rand");
            repeat (20) @(posedge clk);
        end

        // Asynchronous reset in the middle of a measurement.
        riseDly = 5; fallDly = 5;
        repeat (20) @(posedge clk);
        idleCheckEn = 1'b0;
        @(negedge clk);
        num_trials = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_state", fsm_state, 0);
        check("arst_launch", path_launch, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_last", last_delay, 0);
        check("arst_sum", delay_sum, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_min", min_delay, 0);
        check("arst_max", max_delay, 0);
        expLast = '0; expSum = '0; expTo = 1'b0; expLaunch = 1'b0; expMin = '0; expMax = '0;
        riseDly = 0; fallDly = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idleCheckEn = 1'b1;
        repeat (20) @(posedge clk);
        do_run(4, 1'b0, "wire2");
        check("wire2_last", last_delay, 3);
        check("wire2_sum", delay_sum, 12);
        check("wire2_timeout", timeout_err, 0);
        pin_minmax("wire2", 3, 3);
        repeat (5) @(posedge clk);

        idleCheckEn = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
